// File: rtl/fifo_ctrl.sv
// Initiator-side controller for the pulse-handshake fifo store.
// Converts a valid/ready push stream and a request/pulse pop stream into fifo set/get requests and tracks occupancy.
module fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push_valid,
  input  logic [WIDTH-1:0]       i_push_data,
  output logic                   o_push_ready,
  input  logic                   i_pop,
  output logic                   o_pop_ready,
  output logic                   o_pop_valid,
  output logic [WIDTH-1:0]       o_pop_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_fifo_en,
  output logic                   o_fifo_set,
  output logic [WIDTH-1:0]       o_fifo_data,
  output logic                   o_fifo_get,
  input  logic                   i_fifo_set,
  input  logic                   i_fifo_get,
  input  logic [WIDTH-1:0]       i_fifo_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic {
    PUSH_IDLE,
    PUSH_WAIT_ACK
  } push_state_t;

  typedef enum logic [1:0] {
    POP_IDLE,
    POP_WAIT_ACK,
    POP_DELIVER
  } pop_state_t;

  push_state_t      push_state_q, push_state_d;
  pop_state_t       pop_state_q, pop_state_d;
  logic             en_q, en_d;
  logic [CW-1:0]    reserved_q, reserved_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic set_busy, get_busy;
  logic push_ready, pop_ready;
  logic push_acc, pop_acc;
  logic set_ack, get_ack;

  always_comb begin
    set_busy   = (push_state_q == PUSH_WAIT_ACK);
    get_busy   = (pop_state_q == POP_WAIT_ACK);
    push_ready = en_q & ~set_busy & (reserved_q != FULL_LVL);
    // Pops only see acknowledged words so a read never races an in-flight write.
    pop_ready  = en_q & ~get_busy & (count_q != '0);
    push_acc   = i_push_valid & push_ready;
    pop_acc    = i_pop & pop_ready;
    set_ack    = set_busy & i_fifo_set;
    get_ack    = get_busy & i_fifo_get;
  end

  always_comb begin
    push_state_d = push_state_q;
    unique case (push_state_q)
      PUSH_IDLE:     if (push_acc) push_state_d = PUSH_WAIT_ACK;
      PUSH_WAIT_ACK: if (i_fifo_set) push_state_d = PUSH_IDLE;
      default:       push_state_d = PUSH_IDLE;
    endcase
  end

  always_comb begin
    pop_state_d = pop_state_q;
    unique case (pop_state_q)
      POP_IDLE,
      POP_DELIVER:  pop_state_d = pop_acc ? POP_WAIT_ACK : POP_IDLE;
      POP_WAIT_ACK: if (i_fifo_get) pop_state_d = POP_DELIVER;
      default:      pop_state_d = POP_IDLE;
    endcase
  end

  always_comb begin
    en_d    = 1'b1;
    wdata_d = push_acc ? i_push_data : wdata_q;
    rdata_d = get_ack ? i_fifo_data : rdata_q;

    reserved_d = reserved_q;
    unique case ({push_acc, pop_acc})
      2'b10:   reserved_d = reserved_q + ONE;
      2'b01:   reserved_d = reserved_q - ONE;
      default: reserved_d = reserved_q;
    endcase

    count_d = count_q;
    unique case ({set_ack, pop_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_q         <= 1'b0;
      push_state_q <= PUSH_IDLE;
      pop_state_q  <= POP_IDLE;
      reserved_q   <= '0;
      count_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      en_q         <= en_d;
      push_state_q <= push_state_d;
      pop_state_q  <= pop_state_d;
      reserved_q   <= reserved_d;
      count_q      <= count_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign o_push_ready = push_ready;
  assign o_pop_ready  = pop_ready;
  assign o_pop_valid  = (pop_state_q == POP_DELIVER);
  assign o_pop_data   = rdata_q;
  assign o_count      = count_q;
  assign o_full       = (reserved_q == FULL_LVL);
  assign o_empty      = (count_q == '0);
  assign o_fifo_en    = en_q;
  assign o_fifo_set   = set_busy;
  assign o_fifo_data  = wdata_q;
  assign o_fifo_get   = get_busy;

endmodule
